// File: rtl/myrv_pkg.sv
// Shared types and constants for the myrv core control path.
package myrv_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StExec,
    StMem,
    StWb,
    StHalt
  } seq_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/myrv_sequencer.sv
// Multi-cycle sequencer: owns PC and instruction register and walks each
// instruction through fetch, execute, optional memory access and writeback.
module myrv_sequencer
  import myrv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic        dec_mem,
  input  logic        dec_mem_read,
  input  logic        dec_wb,
  input  logic        dec_branch,
  input  logic [31:0] alu_result,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic        retire,
  output logic        fault
);

  seq_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;

  logic mem_op;
  logic take_branch;
  logic target_misaligned;

  // The decoder flags mem on branch/jump encodings; those never touch memory.
  assign mem_op            = dec_mem_read | (dec_mem & ~dec_branch);
  assign take_branch       = dec_branch & branch_taken;
  assign target_misaligned = take_branch & (alu_result[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    fault_d  = fault_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;

    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = mem_op ? StMem : StWb;
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = ~dec_mem_read;
        if (dmem_ready) begin
          state_d = StWb;
        end
      end
      StWb: begin
        if (target_misaligned) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end else begin
          rf_we   = dec_wb;
          retire  = 1'b1;
          pc_d    = take_branch ? alu_result : pc_q + 32'd4;
          state_d = StFetch;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    // Strobes are forced low for the whole reset cycle, whatever the state.
    if (!rst_n) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      retire   = 1'b0;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_myrv_sequencer.sv
// Randomised scoreboard bench for myrv_sequencer; the bench plays memory and decoder.
module tb_myrv_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] instr, pc;
  logic        dec_mem = 1'b0, dec_mem_read = 1'b0, dec_wb = 1'b0, dec_branch = 1'b0;
  logic [31:0] alu_result = '0;
  logic        branch_taken = 1'b0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic        rf_we, retire, fault;

  myrv_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .dec_mem     (dec_mem),
    .dec_mem_read(dec_mem_read),
    .dec_wb      (dec_wb),
    .dec_branch  (dec_branch),
    .alu_result  (alu_result),
    .branch_taken(branch_taken),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ready  (dmem_ready),
    .rf_we       (rf_we),
    .retire      (retire),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem;
    logic        mem_read;
    logic        wb;
    logic        branch;
    logic        taken;
    logic [31:0] alu;
  } dec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic        rf_we;
    logic        dmem_we;
    logic        fault;
    int          lat;
    int          dcyc;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    int          iw;
  } fetch_t;

  dec_t        dec_tab [4096];
  exp_t        exp_q[$];
  fetch_t      imem_q[$];
  int          dw_q[$];
  logic [31:0] pc_m = RESET_PC;
  logic [11:0] tag = 12'h100;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: one record per instruction, from the architectural rules.
  task automatic issue(input logic mem, input logic mr, input logic wb, input logic br,
                       input logic tk, input logic [31:0] alu, input int iw, input int dw);
    exp_t        e;
    fetch_t      f;
    logic [31:0] r;
    logic        memop, taken;
    r     = $urandom();
    f.word = {r[19:0], tag};
    f.iw   = iw;
    dec_tab[tag] = '{mem: mem, mem_read: mr, wb: wb, branch: br, taken: tk, alu: alu};
    tag++;
    memop     = mr | (mem & ~br);
    taken     = br & tk;
    e.addr    = pc_m;
    e.word    = f.word;
    e.fault   = taken && (alu % 4 != 0);
    e.rf_we   = wb && !e.fault;
    e.dmem_we = !mr;
    e.dcyc    = memop ? dw + 1 : 0;
    e.lat     = 3 + iw + e.dcyc;
    if (!e.fault) pc_m = taken ? alu : pc_m + 32'd4;
    exp_q.push_back(e);
    imem_q.push_back(f);
    if (memop) dw_q.push_back(dw);
  endtask

  task automatic issue_rand();
    int          k, iw, dw;
    logic [31:0] r;
    k  = $urandom_range(0, 5);
    iw = $urandom_range(0, 3);
    dw = $urandom_range(0, 3);
    r  = $urandom();
    case (k)
      0: issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, r, iw, dw);
      1: issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, r, iw, dw);
      2: issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, r, iw, dw);
      3: issue(1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), r & ~32'h3, iw, dw);
      4: issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, r & ~32'h3, iw, dw);
      default: issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, r | 32'h1, iw, dw);
    endcase
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    imem_q.delete();
    dw_q.delete();
    pc_m = RESET_PC;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Decoder stand-in: flags looked up by the tag in the low bits of instr.
  initial begin
    dec_t d;
    for (int i = 0; i < 4096; i++) dec_tab[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      d            = dec_tab[instr[11:0]];
      dec_mem      = d.mem;
      dec_mem_read = d.mem_read;
      dec_wb       = d.wb;
      dec_branch   = d.branch;
      branch_taken = d.taken;
      alu_result   = d.alu;
    end
  end

  initial begin
    logic ia = 1'b0;
    int   iwc = 0;
    forever begin
      @(posedge clk);
      #1;
      imem_ready = 1'b0;
      if (!rst_n || !imem_req) begin
        ia = 1'b0;
      end else begin
        if (!ia && imem_q.size() > 0) begin
          ia  = 1'b1;
          iwc = imem_q[0].iw;
        end
        if (ia) begin
          if (iwc == 0) begin
            imem_ready = 1'b1;
            imem_rdata = imem_q[0].word;
            void'(imem_q.pop_front());
            ia = 1'b0;
          end else begin
            iwc--;
          end
        end
      end
    end
  end

  initial begin
    logic da = 1'b0;
    int   dwc = 0;
    forever begin
      @(posedge clk);
      #1;
      dmem_ready = 1'b0;
      if (!rst_n || !dmem_req) begin
        da = 1'b0;
      end else begin
        if (!da && dw_q.size() > 0) begin
          da  = 1'b1;
          dwc = dw_q[0];
        end
        if (da) begin
          if (dwc == 0) begin
            dmem_ready = 1'b1;
            void'(dw_q.pop_front());
            da = 1'b0;
          end else begin
            dwc--;
          end
        end
      end
    end
  end

  // Monitor: pops one record per retire (or per fault) and compares.
  initial begin
    exp_t e;
    int   cyc = 0, fstart = 0, dcnt = 0;
    logic fetching = 1'b0, fault_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fetching   = 1'b0;
        dcnt       = 0;
        fault_seen = 1'b0;
      end else begin
        cyc++;
        if (imem_req) begin
          if (!fetching) begin
            fetching = 1'b1;
            fstart   = cyc;
          end
          if (exp_q.size() > 0) check("imem_addr", imem_addr, exp_q[0].addr);
        end
        if (dmem_req) begin
          dcnt++;
          check("rf_we_during_dmem", rf_we, 0);
          if (exp_q.size() > 0) check("dmem_we", dmem_we, exp_q[0].dmem_we);
        end
        if (retire) begin
          if (exp_q.size() == 0) begin
            check("retire_unexpected", retire, 0);
          end else begin
            e = exp_q.pop_front();
            check("rf_we", rf_we, e.rf_we);
            check("instr", instr, e.word);
            check("pc_at_retire", pc, e.addr);
            check("latency", cyc - fstart + 1, e.lat);
            check("dmem_cycles", dcnt, e.dcyc);
          end
          fetching = 1'b0;
          dcnt     = 0;
        end else begin
          check("rf_we_outside_wb", rf_we, 0);
        end
        if (fault && !fault_seen) begin
          fault_seen = 1'b1;
          if (exp_q.size() == 0) begin
            check("fault_unexpected", fault, 0);
          end else begin
            e = exp_q.pop_front();
            check("fault_expected", fault, e.fault);
            check("fault_pc_held", pc, e.addr);
          end
        end
        if (fault_seen) check("halt_imem_req", imem_req, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] fpc;
    int          n;
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_imem_req", imem_req, 0);
    check("reset_dmem_req", dmem_req, 0);
    check("reset_retire", retire, 0);
    check("reset_pc", pc, RESET_PC);
    check("reset_instr", instr, NOP);
    check("reset_fault", fault, 0);

    // Directed: addi, slow fetch, load, store, taken/untaken branch, PC wrap
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 3, 0);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 0, 2);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 1, 1);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 0, 0);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 0, 0);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 0, 0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
    release_reset();
    drain();

    for (int i = 0; i < 60; i++) issue_rand();
    drain();

    // Misaligned taken target halts with a sticky fault
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
    fpc = pc_m;
    issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, fpc + 32'h42, 0, 0);
    drain();
    repeat (10) begin
      @(negedge clk);
      check("halt_no_fetch", imem_req, 0);
      check("halt_no_retire", retire, 0);
      check("halt_fault", fault, 1);
    end
    check("halt_pc", pc, fpc);

    // Reset out of HALT, then reset again in the middle of a load wait
    assert_reset();
    repeat (2) @(posedge clk);
    #3 check("reset_clears_fault", fault, 0);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 0, 8);
    release_reset();
    n = 0;
    while (!dmem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mem_wait_reached", dmem_req, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    dmem_ready = 1'b1;
    #1;
    check("reset_drops_dmem_req", dmem_req, 0);
    check("reset_drops_rf_we", rf_we, 0);
    exp_q.delete();
    imem_q.delete();
    dw_q.delete();
    pc_m = RESET_PC;
    @(posedge clk);
    #3;
    check("midreset_pc", pc, RESET_PC);
    check("midreset_instr", instr, NOP);
    check("midreset_dmem_req", dmem_req, 0);
    for (int i = 0; i < 30; i++) issue_rand();
    release_reset();
    @(negedge clk);
    check("refetch_req", imem_req, 1);
    check("refetch_addr", imem_addr, RESET_PC);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
